// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with start/ready/done handshake.
// Optional macro SUB_SATURATE_EN floors a borrowing result to zero.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_diff_fin;

  assign w_a       = r_a_sr[0];
  assign w_b       = r_b_sr[0];
  assign w_d       = w_a ^ w_b ^ r_borrow;
  assign w_br_nxt  = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  // Result bits enter at the top, so after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_nxt = {w_d, r_res};

`ifdef SUB_SATURATE_EN
  assign w_diff_fin = w_br_nxt ? {WIDTH{1'b0}} : w_res_nxt;
`else
  assign w_diff_fin = w_res_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_SHIFT;
        else       w_state_nxt = S_IDLE;
      end
      S_SHIFT: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_state_nxt = S_SHIFT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt == S_SHIFT);
      r_done  <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr   <= A;
            r_b_sr   <= B;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_res    <= w_res_nxt[WIDTH-1:1];
          r_borrow <= w_br_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_diff_fin;
            r_bout <= w_br_nxt;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign diff  = r_diff;
  assign bout  = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {borrow, diff}
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x - y;
`ifdef SUB_SATURATE_EN
    if (x < y) d = 8'h00;
`endif
    return {(x < y), d};
  endfunction

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input string tag, input bit full);
    int cyc;
    logic [8:0] exp_v;
    exp_v = ref_sub(x, y);
    @(negedge clk);
    if (full) check_eq({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    if (full) begin
      check_eq({tag, "_latency"}, cyc, 32'd9);
      check_eq({tag, "_ready_in_done"}, {31'd0, ready}, 32'd0);
      check_eq({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    end
    check_eq({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_v[7:0]});
    check_eq({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_v[8]});
    if (full) begin
      @(negedge clk);
      check_eq({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
      check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_diff_held"}, {24'd0, diff}, {24'd0, exp_v[7:0]});
    end
  endtask

  initial begin
    int         n_done;
    int         last_t;
    logic [7:0] cap_diff;
    logic [7:0] rx;
    logic [7:0] ry;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_diff", {24'd0, diff}, 32'd0);
    check_eq("rst_bout", {31'd0, bout}, 32'd0);

    run_op(8'h05, 8'h03, "t1", 1'b1);
    run_op(8'h03, 8'h05, "t2", 1'b1);
    run_op(8'hFF, 8'hFF, "t3a", 1'b1);
    run_op(8'h00, 8'h01, "t3b", 1'b1);

    // Second start mid-operation must be ignored
    @(negedge clk);
    a_in  = 8'h80;
    b_in  = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_in  = 8'h10;
    start = 1'b1;
    check_eq("t4_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start    = 1'b0;
    n_done   = 0;
    cap_diff = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        cap_diff = diff;
      end
    end
    check_eq("t4_ndone", n_done, 32'd1);
    check_eq("t4_diff", {24'd0, cap_diff}, 32'h7F);

    // Reset during the 4th shift cycle discards the operation
    @(negedge clk);
    a_in  = 8'h33;
    b_in  = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_ready", {31'd0, ready}, 32'd1);
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_diff", {24'd0, diff}, 32'd0);
    check_eq("t5_bout", {31'd0, bout}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("t5_ndone", n_done, 32'd0);

    // Continuous start: one result every 10 cycles
    @(negedge clk);
    a_in   = 8'h0A;
    b_in   = 8'h04;
    start  = 1'b1;
    n_done = 0;
    last_t = 0;
    for (int t = 1; t <= 35; t++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check_eq("t6_diff", {24'd0, diff}, 32'h06);
        if (n_done == 1) check_eq("t6_first", t, 32'd9);
        else             check_eq("t6_period", t - last_t, 32'd10);
        last_t = t;
      end
    end
    check_eq("t6_ndone", n_done, 32'd3);
    start = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check_eq("t6_idle", {31'd0, ready}, 32'd1);

    // Random operands against the reference
    for (int k = 0; k < 1000; k++) begin
      rx = 8'($urandom_range(255, 0));
      ry = 8'($urandom_range(255, 0));
      run_op(rx, ry, "rnd", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
